// File: rtl/gshare_bht_ctrl.sv
// Gshare branch history table controller: sweeps the counter array after reset,
// serves combinational lookups and applies resolved outcomes to saturating counters.
module gshare_bht_ctrl #(
    parameter int              CTR_W    = 2,
    parameter logic [CTR_W-1:0] INIT_CTR = CTR_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    output logic             pred_taken,
    output logic [3:0]       pred_ghr,
    output logic             pred_ready,
    input  logic             resolve_valid,
    input  logic [31:0]      resolve_pc,
    input  logic [3:0]       resolve_ghr,
    input  logic             resolve_taken,
    input  logic             mispredict,
    output logic             tbl_write_a,
    output logic [3:0]       tbl_index_a,
    output logic [CTR_W-1:0] tbl_datain_a,
    input  logic [CTR_W-1:0] tbl_dataout_a,
    output logic             tbl_write_b,
    output logic [3:0]       tbl_index_b,
    output logic [CTR_W-1:0] tbl_datain_b,
    input  logic [CTR_W-1:0] tbl_dataout_b
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

    // Saturating counter step; never wraps at either end.
    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c, input logic up);
        logic [CTR_W-1:0] r;
        if (up) begin
            r = (c == CTR_MAX) ? c : c + CTR_W'(1);
        end else begin
            r = (c == CTR_MIN) ? c : c - CTR_W'(1);
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       sweep_q, sweep_d;
    logic [3:0]       ghr_q, ghr_d;
    logic             upd_v_q, upd_v_d;
    logic [3:0]       upd_idx_q, upd_idx_d;
    logic             upd_taken_q, upd_taken_d;

    logic [3:0]       lookup_idx_s;
    logic [CTR_W-1:0] new_ctr_s;
    logic [CTR_W-1:0] eff_ctr_s;
    logic             unused_s;

    assign lookup_idx_s = fetch_pc[5:2] ^ ghr_q;
    assign new_ctr_s    = sat_step(tbl_dataout_b, upd_taken_q);
    assign unused_s     = ^{fetch_pc[31:6], fetch_pc[1:0], resolve_pc[31:6], resolve_pc[1:0]};
    assign tbl_write_a  = 1'b0;
    assign tbl_datain_a = CTR_MIN;

    // State, sweep, history and update-pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_q     <= 4'd0;
            ghr_q       <= 4'd0;
            upd_v_q     <= 1'b0;
            upd_idx_q   <= 4'd0;
            upd_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            ghr_q       <= ghr_d;
            upd_v_q     <= upd_v_d;
            upd_idx_q   <= upd_idx_d;
            upd_taken_q <= upd_taken_d;
        end
    end

    // Next-state: sweep in INIT; history and update capture in RUN.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        ghr_d       = ghr_q;
        upd_v_d     = 1'b0;
        upd_idx_d   = upd_idx_q;
        upd_taken_d = upd_taken_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 4'd1;
                if (sweep_q == 4'd15) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                // Recovery wins over the speculative shift of a same-cycle fetch.
                if (resolve_valid && mispredict) begin
                    ghr_d = {resolve_ghr[2:0], resolve_taken};
                end else if (fetch_valid) begin
                    ghr_d = {ghr_q[2:0], pred_taken};
                end else begin
                    ghr_d = ghr_q;
                end
                upd_v_d     = resolve_valid;
                upd_idx_d   = resolve_pc[5:2] ^ resolve_ghr;
                upd_taken_d = resolve_taken;
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = 4'd0;
            end
        endcase
    end

    // Array port drive, prediction and bypass of the in-flight update.
    always_comb begin
        pred_taken   = 1'b0;
        pred_ready   = 1'b0;
        pred_ghr     = ghr_q;
        tbl_index_a  = 4'd0;
        tbl_write_b  = 1'b0;
        tbl_index_b  = 4'd0;
        tbl_datain_b = CTR_MIN;
        eff_ctr_s    = tbl_dataout_a;
        case (state_q)
            ST_INIT: begin
                tbl_index_b = sweep_q;
                if (!rst) begin
                    tbl_write_b  = 1'b1;
                    tbl_datain_b = INIT_CTR;
                end else begin
                    tbl_write_b  = 1'b0;
                    tbl_datain_b = CTR_MIN;
                end
            end
            ST_RUN: begin
                pred_ready  = 1'b1;
                tbl_index_a = lookup_idx_s;
                if (upd_v_q && (upd_idx_q == lookup_idx_s)) begin
                    eff_ctr_s = new_ctr_s;
                end else begin
                    eff_ctr_s = tbl_dataout_a;
                end
                pred_taken = eff_ctr_s[CTR_W-1];
                if (upd_v_q) begin
                    tbl_write_b  = 1'b1;
                    tbl_index_b  = upd_idx_q;
                    tbl_datain_b = new_ctr_s;
                end else begin
                    tbl_write_b  = 1'b0;
                end
            end
            default: begin
                pred_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gshare_bht_ctrl.sv
// Bench for gshare_bht_ctrl: models the 16-entry array, runs directed vectors
// and randomized traffic against an abstract predictor model.
module tb_gshare_bht_ctrl;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [3:0]  pred_ghr;
    logic        pred_ready;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic [3:0]  resolve_ghr;
    logic        resolve_taken;
    logic        mispredict;
    logic        tbl_write_a;
    logic [3:0]  tbl_index_a;
    logic [1:0]  tbl_datain_a;
    logic [1:0]  tbl_dataout_a;
    logic        tbl_write_b;
    logic [3:0]  tbl_index_b;
    logic [1:0]  tbl_datain_b;
    logic [1:0]  tbl_dataout_b;

    logic [1:0]  mem [16];

    int n_vec = 0;
    int n_mis = 0;

    // Abstract predictor state: counters as integers, history as an integer.
    int m_ready, m_sweep, m_ghr, m_pv, m_pidx, m_pt;
    int m_ctr [16];

    typedef struct {
        bit          fv;
        logic [31:0] fpc;
        bit          rv;
        logic [31:0] rpc;
        logic [3:0]  rghr;
        bit          rt;
        bit          mp;
        bit          e_pt;
        logic [3:0]  e_ghr;
        bit          e_wb;
        logic [3:0]  e_ib;
        logic [1:0]  e_db;
    } vec_t;

    vec_t vecs [13];

    gshare_bht_ctrl #(.CTR_W(2), .INIT_CTR(2'b01)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_ghr(pred_ghr), .pred_ready(pred_ready),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_ghr(resolve_ghr),
        .resolve_taken(resolve_taken), .mispredict(mispredict),
        .tbl_write_a(tbl_write_a), .tbl_index_a(tbl_index_a),
        .tbl_datain_a(tbl_datain_a), .tbl_dataout_a(tbl_dataout_a),
        .tbl_write_b(tbl_write_b), .tbl_index_b(tbl_index_b),
        .tbl_datain_b(tbl_datain_b), .tbl_dataout_b(tbl_dataout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The array itself: no reset, asynchronous read, two write ports.
    always @(posedge clk) begin
        if (tbl_write_a) mem[tbl_index_a] <= tbl_datain_a;
        if (tbl_write_b) mem[tbl_index_b] <= tbl_datain_b;
    end
    assign tbl_dataout_a = mem[tbl_index_a];
    assign tbl_dataout_b = mem[tbl_index_b];

    function automatic vec_t mk(bit fv, logic [31:0] fpc, bit rv, logic [31:0] rpc,
                                logic [3:0] rghr, bit rt, bit mp, bit e_pt,
                                logic [3:0] e_ghr, bit e_wb, logic [3:0] e_ib, logic [1:0] e_db);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.rghr = rghr; v.rt = rt; v.mp = mp;
        v.e_pt = e_pt; v.e_ghr = e_ghr; v.e_wb = e_wb; v.e_ib = e_ib; v.e_db = e_db;
        return v;
    endfunction

    function automatic int sat(int c, int up);
        if (up != 0) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit fv, logic [31:0] fpc, bit rv, logic [31:0] rpc,
                         logic [3:0] rghr, bit rt, bit mp);
        fetch_valid = fv; fetch_pc = fpc; resolve_valid = rv; resolve_pc = rpc;
        resolve_ghr = rghr; resolve_taken = rt; mispredict = mp;
    endtask

    task automatic model_reset();
        m_ready = 0; m_sweep = 0; m_ghr = 0; m_pv = 0; m_pidx = 0; m_pt = 0;
    endtask

    // Prediction the abstract model makes for the current fetch.
    function automatic int model_pred();
        int idx, c;
        idx = ((int'(fetch_pc) >> 2) & 15) ^ m_ghr;
        c = (m_pv != 0 && m_pidx == idx) ? sat(m_ctr[idx], m_pt) : m_ctr[idx];
        return (c >= 2) ? 1 : 0;
    endfunction

    task automatic model_check();
        chk("write_a", {31'd0, tbl_write_a}, 32'd0);
        chk("pred_ghr", {28'd0, pred_ghr}, m_ghr);
        if (m_ready == 0) begin
            chk("init_ready", {31'd0, pred_ready}, 32'd0);
            chk("init_pt", {31'd0, pred_taken}, 32'd0);
            chk("sweep_wb", {31'd0, tbl_write_b}, 32'd1);
            chk("sweep_ib", {28'd0, tbl_index_b}, m_sweep);
            chk("sweep_db", {30'd0, tbl_datain_b}, 32'd1);
        end else begin
            chk("run_ready", {31'd0, pred_ready}, 32'd1);
            chk("lookup_idx", {28'd0, tbl_index_a}, ((int'(fetch_pc) >> 2) & 15) ^ m_ghr);
            chk("pred_taken", {31'd0, pred_taken}, model_pred());
            chk("upd_wb", {31'd0, tbl_write_b}, m_pv);
            if (m_pv != 0) begin
                chk("upd_ib", {28'd0, tbl_index_b}, m_pidx);
                chk("upd_db", {30'd0, tbl_datain_b}, sat(m_ctr[m_pidx], m_pt));
            end
        end
    endtask

    task automatic model_step();
        int pt;
        if (m_ready == 0) begin
            m_ctr[m_sweep] = 1;
            m_sweep++;
            if (m_sweep == 16) m_ready = 1;
        end else begin
            pt = model_pred();
            if (m_pv != 0) m_ctr[m_pidx] = sat(m_ctr[m_pidx], m_pt);
            if (resolve_valid && mispredict)
                m_ghr = ((int'(resolve_ghr) << 1) | int'(resolve_taken)) & 15;
            else if (fetch_valid)
                m_ghr = ((m_ghr << 1) | pt) & 15;
            m_pv = resolve_valid ? 1 : 0;
            m_pidx = ((int'(resolve_pc) >> 2) & 15) ^ int'(resolve_ghr);
            m_pt = resolve_taken ? 1 : 0;
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_cycle(bit fv, logic [31:0] fpc, bit rv, logic [31:0] rpc,
                             logic [3:0] rghr, bit rt, bit mp);
        drive(fv, fpc, rv, rpc, rghr, rt, mp);
        @(negedge clk);
        model_check();
        finish_cycle();
    endtask

    // Sweep with random fetch/resolve noise that must be ignored, then the ready cycle.
    task automatic do_sweep();
        for (int i = 0; i < 16; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, $urandom,
                  4'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            @(negedge clk);
            chk("sweep_index", {28'd0, tbl_index_b}, i);
            model_check();
            finish_cycle();
        end
        run_cycle(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) chk("swept_entry", {30'd0, mem[i]}, 32'd1);
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h10, 0, 32'h00, 4'd0, 0, 0, 0, 4'd0,  0, 4'd0, 2'd0);
        vecs[1]  = mk(0, 32'h10, 1, 32'h10, 4'd0, 1, 0, 0, 4'd0,  0, 4'd0, 2'd0);
        vecs[2]  = mk(1, 32'h10, 1, 32'h10, 4'd0, 1, 0, 1, 4'd0,  1, 4'd4, 2'd2);
        vecs[3]  = mk(0, 32'h10, 1, 32'h10, 4'd0, 1, 0, 0, 4'd1,  1, 4'd4, 2'd3);
        vecs[4]  = mk(0, 32'h10, 0, 32'h00, 4'd0, 0, 0, 0, 4'd1,  1, 4'd4, 2'd3);
        vecs[5]  = mk(1, 32'h14, 0, 32'h00, 4'd0, 0, 0, 1, 4'd1,  0, 4'd0, 2'd0);
        vecs[6]  = mk(0, 32'h00, 1, 32'h10, 4'd0, 0, 0, 0, 4'd3,  0, 4'd0, 2'd0);
        vecs[7]  = mk(0, 32'h00, 1, 32'h10, 4'd0, 0, 0, 0, 4'd3,  1, 4'd4, 2'd2);
        vecs[8]  = mk(0, 32'h00, 1, 32'h10, 4'd0, 0, 0, 0, 4'd3,  1, 4'd4, 2'd1);
        vecs[9]  = mk(0, 32'h00, 1, 32'h10, 4'd0, 0, 0, 0, 4'd3,  1, 4'd4, 2'd0);
        vecs[10] = mk(0, 32'h00, 0, 32'h00, 4'd0, 0, 0, 0, 4'd3,  1, 4'd4, 2'd0);
        vecs[11] = mk(1, 32'h00, 1, 32'h00, 4'd5, 1, 1, 0, 4'd3,  0, 4'd0, 2'd0);
        vecs[12] = mk(0, 32'h00, 0, 32'h00, 4'd0, 0, 0, 0, 4'd11, 1, 4'd5, 2'd2);

        for (int i = 0; i < 16; i++) m_ctr[i] = 0;
        model_reset();
        rst = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h10, 4'd0, 1'b1, 1'b1);
        #12;
        chk("rst_pt", {31'd0, pred_taken}, 32'd0);
        chk("rst_ready", {31'd0, pred_ready}, 32'd0);
        chk("rst_ghr", {28'd0, pred_ghr}, 32'd0);
        chk("rst_wa", {31'd0, tbl_write_a}, 32'd0);
        chk("rst_wb", {31'd0, tbl_write_b}, 32'd0);
        chk("rst_ia", {28'd0, tbl_index_a}, 32'd0);
        chk("rst_ib", {28'd0, tbl_index_b}, 32'd0);
        chk("rst_da", {30'd0, tbl_datain_a}, 32'd0);
        chk("rst_db", {30'd0, tbl_datain_b}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_sweep();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].fv, vecs[i].fpc, vecs[i].rv, vecs[i].rpc,
                  vecs[i].rghr, vecs[i].rt, vecs[i].mp);
            @(negedge clk);
            chk("vec_pt", {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
            chk("vec_ghr", {28'd0, pred_ghr}, {28'd0, vecs[i].e_ghr});
            chk("vec_wb", {31'd0, tbl_write_b}, {31'd0, vecs[i].e_wb});
            if (vecs[i].e_wb) begin
                chk("vec_ib", {28'd0, tbl_index_b}, {28'd0, vecs[i].e_ib});
                chk("vec_db", {30'd0, tbl_datain_b}, {30'd0, vecs[i].e_db});
            end
            model_check();
            finish_cycle();
        end

        // Pending update to entry 5 must be dropped by a mid-run reset.
        run_cycle(1'b0, 32'd0, 1'b1, 32'h14, 4'd0, 1'b1, 1'b0);
        #1 rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        model_reset();
        #1;
        chk("midrst_wb", {31'd0, tbl_write_b}, 32'd0);
        chk("midrst_ready", {31'd0, pred_ready}, 32'd0);
        chk("midrst_ghr", {28'd0, pred_ghr}, 32'd0);
        chk("midrst_ib", {28'd0, tbl_index_b}, 32'd0);
        @(posedge clk);
        #1;
        chk("dropped_update", {30'd0, mem[5]}, 32'd2);
        rst = 1'b0;
        do_sweep();

        for (int i = 0; i < 600; i++) begin
            run_cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0, $urandom,
                      4'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
